// File: rtl/mult_requester.sv
// Purpose : initiator side of the shift-add multiplier handshake; takes an
//           operand pair from upstream, starts the core, collects the product
//           and hands it downstream, with a watchdog against a hung core.
// Latency : accept at cycle 0 -> mul_valid_data at 1; done first seen at k ->
//           mul_ack at k+1, res_valid at k+2. Watchdog fires after TIMEOUT
//           cycles in WAIT.
// Backpres: in_ready only in IDLE; the result is held in OUT until res_ready,
//           so a stalled consumer stalls new operand acceptance.
//
// Ports:
//   Clock, Reset           rising-edge clock, async active-high reset
//   in_valid/in_ready      upstream operand handshake, operands in_a/in_b
//   mul_a/mul_b            registered operands presented to the core
//   mul_valid_data         one-cycle start pulse to the core
//   mul_done/mul_product   core completion level and its product
//   mul_ack                one-cycle result-read acknowledge to the core
//   res_valid/res_ready    downstream result handshake
//   res_product            captured product (zero on timeout)
//   res_timeout            qualifies res_valid: the core never answered
//   op_count               completed operations, timeouts included, wraps

module mult_requester #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40   // must be >= 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_valid_data,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 mul_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_product,
    output logic                 res_timeout,
    output logic [15:0]          op_count
);

    // Timer must be able to hold TIMEOUT itself so it can saturate there.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 to_q, to_d;
    logic [15:0]          cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        to_d    = to_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Operands stay latched here until the next accept.
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                // A done arriving on the last allowed cycle still counts:
                // it is tested before the expiry.
                if (mul_done) begin
                    prod_d  = mul_product;
                    to_d    = 1'b0;
                    state_d = S_ACK;
                end else if (timer_q == TIMER_LAST) begin
                    prod_d  = '0;
                    to_d    = 1'b1;
                    state_d = S_ACK;
                end
            end

            // The ack is sent on timeouts too, so a core that finishes late
            // is still pushed back toward its idle state.
            S_ACK: begin
                state_d = S_OUT;
            end

            S_OUT: begin
                if (res_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: registers or pure state decodes, no input-to-output paths
    // ------------------------------------------------------------------
    assign in_ready       = (state_q == S_IDLE);
    assign mul_valid_data = (state_q == S_ISSUE);
    assign mul_ack        = (state_q == S_ACK);
    assign res_valid      = (state_q == S_OUT);
    assign mul_a          = a_q;
    assign mul_b          = b_q;
    assign res_product    = prod_q;
    assign res_timeout    = to_q;
    assign op_count       = cnt_q;

endmodule

// File: tb/tb_mult_requester.sv
module tb_mult_requester;

    localparam int W  = 32;
    localparam int TO = 40;

    logic            Clock;
    logic            Reset;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a, in_b;
    logic [W-1:0]    mul_a, mul_b;
    logic            mul_valid_data;
    logic            mul_done;
    logic [2*W-1:0]  mul_product;
    logic            mul_ack;
    logic            res_valid;
    logic            res_ready;
    logic [2*W-1:0]  res_product;
    logic            res_timeout;
    logic [15:0]     op_count;

    mult_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_valid_data (mul_valid_data),
        .mul_done       (mul_done),
        .mul_product    (mul_product),
        .mul_ack        (mul_ack),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_product    (res_product),
        .res_timeout    (res_timeout),
        .op_count       (op_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Period index: value of cyc between two rising edges.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: each operation is a timeline of period
    // numbers derived from the accept cycle and the core response delay.
    // ------------------------------------------------------------------
    bit             chk_en = 0;
    bit             have_op = 0;
    int             m_t0 = -10, m_tiss = -10, m_tack = -10, m_tout = -10, m_tend = -10;
    logic [W-1:0]   m_a = '0, m_b = '0, m_a_old = '0, m_b_old = '0;
    logic [2*W-1:0] m_prod = '0;
    logic           m_to = 1'b0;
    logic [15:0]    m_base = '0;

    task automatic model_reset();
        have_op = 0;
        m_t0 = -10; m_tiss = -10; m_tack = -10; m_tout = -10; m_tend = -10;
        m_a = '0; m_b = '0; m_a_old = '0; m_b_old = '0;
        m_prod = '0; m_to = 1'b0; m_base = '0;
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            int          p;
            bit          busy, outw;
            logic [15:0] ec;
            p    = cyc;
            busy = (p > m_t0) && (p <= m_tend);
            outw = (p >= m_tout) && (p <= m_tend);
            ec   = m_base + ((have_op && p > m_tend) ? 16'd1 : 16'd0);
            check("in_ready",       in_ready,       !busy);
            check("mul_valid_data", mul_valid_data, p == m_tiss);
            check("mul_ack",        mul_ack,        p == m_tack);
            check("res_valid",      res_valid,      outw);
            check("mul_a", mul_a, (p > m_t0) ? m_a : m_a_old);
            check("mul_b", mul_b, (p > m_t0) ? m_b : m_b_old);
            check("op_count", op_count, ec);
            if (outw) begin
                check("res_product", res_product, m_prod);
                check("res_timeout", res_timeout, m_to);
            end
        end
    end

    // Observations collected while an operation runs.
    int             n_vd, n_ack, o_vd, o_ack, n_rv, n_unstable, n_ir;
    logic [2*W-1:0] o_prod;
    logic           o_to;

    // Starts one operation in the current period (DUT must be idle), plays
    // the core (done after dly cycles, <1 = never) and the consumer (ready
    // after hold cycles in OUT). pre drives the next operands during OUT.
    // abort >= 0 returns early at period issue+abort.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] prod, input int dly, input int hold,
                          input bit pre, input logic [W-1:0] na, input logic [W-1:0] nb,
                          input int abort);
        bit ack_seen;
        bit rv_seen;
        in_valid = 1'b1; in_a = a; in_b = b;
        if (have_op) m_base = m_base + 16'd1;
        have_op = 1;
        m_a_old = m_a; m_b_old = m_b; m_a = a; m_b = b;
        m_t0 = cyc; m_tiss = cyc + 1;
        if (dly >= 1 && dly <= TO) begin
            m_tack = m_tiss + dly + 1; m_prod = prod; m_to = 1'b0;
        end else begin
            m_tack = m_tiss + TO + 1; m_prod = '0; m_to = 1'b1;
        end
        m_tout = m_tack + 1;
        m_tend = m_tout + hold;
        n_vd = 0; n_ack = 0; o_vd = -1; o_ack = -1; n_rv = 0; n_unstable = 0; n_ir = 0;
        o_prod = '1; o_to = 1'bx;
        ack_seen = 0; rv_seen = 0;
        while (cyc <= m_tend) begin
            if (abort >= 0 && cyc == m_tiss + abort) break;
            mul_done    = (dly >= 1) && (cyc >= m_tiss + dly) && !ack_seen;
            mul_product = mul_done ? prod : 64'hBAD0_BAD0_BAD0_BAD0;
            res_ready   = (cyc == m_tend);
            if (cyc > m_t0) begin
                if (pre && cyc >= m_tout) begin
                    in_valid = 1'b1; in_a = na; in_b = nb;
                end else begin
                    // Junk offered while busy must never be latched.
                    in_valid = (cyc < m_tend); in_a = ~a; in_b = ~b;
                end
            end
            if (in_ready) n_ir++;
            if (mul_valid_data) begin n_vd++; if (o_vd < 0) o_vd = cyc; end
            if (mul_ack) begin n_ack++; if (o_ack < 0) o_ack = cyc; ack_seen = 1; end
            if (res_valid) begin
                n_rv++;
                if (!rv_seen) begin rv_seen = 1; o_prod = res_product; o_to = res_timeout; end
                else if (res_product !== o_prod || res_timeout !== o_to) n_unstable++;
            end
            @(posedge Clock); #1;
        end
        mul_done = 1'b0; res_ready = 1'b0;
        if (!pre) in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int te;
        Reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        mul_done = 1'b0; mul_product = '0; res_ready = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset mul_valid_data", mul_valid_data, 0);
        check("reset mul_ack", mul_ack, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_product", res_product, 0);
        check("reset op_count", op_count, 0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(posedge Clock); #1;
        chk_en = 1;
        @(posedge Clock); #1;

        // 3 x 5, core answers 33 cycles after the start pulse.
        run_op(32'd3, 32'd5, 64'd15, 33, 0, 0, '0, '0, -1);
        check("op1 vd pulses", n_vd, 1);
        check("op1 ack pulses", n_ack, 1);
        check("op1 ack-vd", o_ack - o_vd, 34);
        check("op1 product", o_prod, 64'd15);
        check("op1 timeout", o_to, 0);
        check("op1 count", op_count, 1);
        check("op1 mul_a", mul_a, 32'd3);
        check("op1 mul_b", mul_b, 32'd5);

        // Full-scale operands, product passed through unmodified.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 2, 0, '0, '0, -1);
        check("op2 product", o_prod, 64'hFFFF_FFFE_0000_0001);
        check("op2 timeout", o_to, 0);
        check("op2 count", op_count, 2);

        // Core never answers: watchdog after 40 WAIT cycles.
        run_op(32'd7, 32'd9, 64'd63, -1, 1, 0, '0, '0, -1);
        check("op3 ack-vd", o_ack - o_vd, 41);
        check("op3 ack pulses", n_ack, 1);
        check("op3 product", o_prod, 64'd0);
        check("op3 timeout", o_to, 1);
        check("op3 count", op_count, 3);

        // Consumer stalls 10 cycles while the next operands wait.
        run_op(32'h1234, 32'h10, 64'h12340, 3, 10, 1, 32'hAAAA, 32'h5555, -1);
        te = m_tend;
        check("op4 res_valid cycles", n_rv, 11);
        check("op4 unstable", n_unstable, 0);
        check("op4 in_ready cycles", n_ir, 1);
        check("op4 mul_a held", mul_a, 32'h1234);

        // Accepted in the IDLE period right after; done on the last timer cycle.
        run_op(32'hAAAA, 32'h5555, 64'd954408050, 40, 0, 0, '0, '0, -1);
        check("op5 vd cycle", o_vd - te, 2);
        check("op5 ack-vd", o_ack - o_vd, 41);
        check("op5 product", o_prod, 64'd954408050);
        check("op5 timeout", o_to, 0);

        // Done one cycle too late: timeout, late done in ACK/OUT ignored.
        run_op(32'd2, 32'd2, 64'd4, 41, 3, 0, '0, '0, -1);
        check("op6 product", o_prod, 64'd0);
        check("op6 timeout", o_to, 1);
        check("op6 count", op_count, 6);

        // Reset in the middle of WAIT.
        run_op(32'h11, 32'h22, 64'h242, -1, 0, 0, '0, '0, 10);
        chk_en = 0;
        Reset = 1'b1;
        #1;
        check("midrst in_ready", in_ready, 1);
        check("midrst mul_valid_data", mul_valid_data, 0);
        check("midrst mul_ack", mul_ack, 0);
        check("midrst res_valid", res_valid, 0);
        check("midrst res_timeout", res_timeout, 0);
        check("midrst mul_a", mul_a, 0);
        check("midrst op_count", op_count, 0);
        model_reset();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(posedge Clock); #1;
        chk_en = 1;

        run_op(32'd6, 32'd7, 64'd42, 2, 0, 0, '0, '0, -1);
        check("op8 ack-vd", o_ack - o_vd, 3);
        check("op8 product", o_prod, 64'd42);
        check("op8 count", op_count, 1);

        repeat (3) @(posedge Clock);
        #1 chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_requester.md
Name: mult_requester

Overview:
- Initiator side of the shift-add multiplier handshake: accepts operand pairs from an upstream source (valid/ready) and presents them to the multiplier core.
- Drives valid_data, waits for the core's done flag, and captures the 2*WIDTH product.
- Returns the done/ack acknowledge, then delivers the result downstream (valid/ready).
- Includes a timeout watchdog so a hung core cannot stall the host.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- TIMEOUT, 40, max cycles spent in WAIT before abandoning the operation (must be >= 2).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- mul_a  output  WIDTH  operand a to core, registered.
- mul_b  output  WIDTH  operand b to core, registered.
- mul_valid_data  output  1  start request to core.
- mul_done  input  1  core done flag (level, held until ack).
- mul_product  input  2*WIDTH  core product.
- mul_ack  output  1  result-read acknowledge to core.
- res_valid  output  1  result valid downstream.
- res_ready  input  1  downstream accepts result.
- res_product  output  2*WIDTH  captured product.
- res_timeout  output  1  qualifies res_valid: operation timed out.
- op_count  output  16  completed operations (including timeouts), wraps at 0xFFFF -> 0.

Behaviour:
- Reset values: in_ready=1 (state IDLE), all other outputs 0, timer=0, op_count=0. Reset is asynchronous at any time, including mid-operation: state returns to IDLE and the captured result is discarded. The core shares Reset.
- All outputs are registered or Moore-decoded from state; no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT, ACK, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_a/in_b into mul_a/mul_b, go to ISSUE.
  - in_valid=0: stay.
- ISSUE:
  - mul_valid_data=1 for exactly one cycle; timer cleared.
  - Always go to WAIT.
- WAIT:
  - mul_valid_data=0; timer increments each cycle, saturating.
  - mul_done=1: capture mul_product into res_product, res_timeout=0, go to ACK.
  - Else if timer==TIMEOUT-1: res_product=0, res_timeout=1, go to ACK.
  - mul_done and timer expiry in the same cycle: done wins.
- ACK:
  - mul_ack=1 for exactly one cycle (core leaves DONE on ack).
  - On a timeout, ack is still issued to force the core toward IDLE.
  - Always go to OUT.
- OUT:
  - res_valid=1; res_product and res_timeout held stable.
  - On res_ready=1: op_count+1, go to IDLE.
- mul_done outside WAIT is ignored.
- mul_a/mul_b hold their latched values until the next accept.
- in_ready=0 in every state except IDLE. Accept is a single-cycle in_valid&in_ready; there is one bubble cycle between a result accept and the next operand accept.
- Latency: accept at cycle 0 -> mul_valid_data at cycle 1. If done is first seen at cycle k, mul_ack is at k+1 and res_valid at k+2.
- Timer width: ceil(log2(TIMEOUT+1)). No arithmetic is done on operands; the product is passed through unmodified.

Test Plan:
- a=3, b=5; core model asserts done 33 cycles after valid_data with product 15 -> exactly one mul_valid_data pulse, one mul_ack pulse, res_product=15, res_timeout=0, op_count=1.
- a=b=0xFFFFFFFF -> res_product=0xFFFFFFFE00000001, res_timeout=0.
- Core never asserts done -> mul_ack pulses after TIMEOUT=40 cycles in WAIT; res_valid=1, res_timeout=1, res_product=0; op_count increments on accept.
- res_ready held low 10 cycles in OUT -> res_valid, res_product, res_timeout stable. A second in_valid is not accepted (in_ready=0); it is accepted the cycle after IDLE re-entry.
- mul_done rises on the same cycle timer reaches TIMEOUT-1 -> product captured, res_timeout=0.
- Reset asserted mid-WAIT -> all outputs 0, in_ready=1, op_count=0 immediately; a new operation after release completes normally.
